regfile_mp: RTL



---
 rtl/regfile_mp.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register bank with producer scoreboard; reads/hazards combinational, writes/scoreboard on i_clk edge.
// No backpressure: every enabled write and issue is accepted; optional REGFILE_BYPASS_EN adds write-to-read forwarding.
module regfile_mp #(
    parameter int NUMBER_OF_REGISTERS = 32,
    parameter int REGISTERS_SIZE      = 32,
    parameter int NUM_READ_PORTS      = 2,
    parameter int NUM_WRITE_PORTS     = 1,
    localparam int AW                 = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic                                          i_flush,
    input  logic [NUM_WRITE_PORTS-1:0]                    i_enable_wr,
    input  logic [NUM_WRITE_PORTS*AW-1:0]                 i_wr,
    input  logic [NUM_WRITE_PORTS*REGISTERS_SIZE-1:0]     i_data_wr,
    input  logic [NUM_READ_PORTS*AW-1:0]                  i_rd,
    output logic [NUM_READ_PORTS*REGISTERS_SIZE-1:0]      o_data_rd,
    input  logic                                          i_issue,
    input  logic [AW-1:0]                                 i_issue_rd,
    output logic [NUM_READ_PORTS-1:0]                     o_rd_pending,
    output logic                                          o_stall,
    output logic [NUMBER_OF_REGISTERS-1:0]                o_pending_mask,
    output logic [NUMBER_OF_REGISTERS*REGISTERS_SIZE-1:0] o_Debugging
);

    logic [REGISTERS_SIZE-1:0]      regs [NUMBER_OF_REGISTERS];
    logic [NUMBER_OF_REGISTERS-1:0] sb;
    logic [NUMBER_OF_REGISTERS-1:0] sb_next;

    logic [AW-1:0]             wr_addr [NUM_WRITE_PORTS];
    logic [REGISTERS_SIZE-1:0] wr_data [NUM_WRITE_PORTS];
    logic [NUM_WRITE_PORTS-1:0] wr_hit;

    for (genvar k = 0; k < NUM_WRITE_PORTS; k++) begin : g_wr
        assign wr_addr[k] = i_wr[k*AW +: AW];
        assign wr_data[k] = i_data_wr[k*REGISTERS_SIZE +: REGISTERS_SIZE];
        assign wr_hit[k]  = i_enable_wr[k] && (wr_addr[k] != '0);
    end

    // Later ports overwrite earlier ones, so the highest-index port wins a collision.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int j = 0; j < NUMBER_OF_REGISTERS; j++) begin
                regs[j] <= '0;
            end
            sb <= '0;
        end else begin
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                if (wr_hit[k]) begin
                    regs[wr_addr[k]] <= wr_data[k];
                end
            end
            sb <= sb_next;
        end
    end

    // Issue is applied after writeback clears so a new producer supersedes the retiring one.
    always_comb begin
        sb_next = sb;
        if (i_flush) begin
            sb_next = '0;
        end else begin
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                if (wr_hit[k]) begin
                    sb_next[wr_addr[k]] = 1'b0;
                end
            end
            if (i_issue && (i_issue_rd != '0)) begin
                sb_next[i_issue_rd] = 1'b1;
            end
        end
        sb_next[0] = 1'b0;
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        logic [AW-1:0]             ra;
        logic [REGISTERS_SIZE-1:0] rdat;
        logic                      pend;

        assign ra = i_rd[p*AW +: AW];

        always_comb begin
            rdat = regs[ra];
            pend = sb[ra];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                if (wr_hit[k] && (wr_addr[k] == ra)) begin
                    rdat = wr_data[k];
                    pend = 1'b0;
                end
            end
`else
            // Without forwarding decode must hold one more cycle on a write/read collision.
`endif
        end

        assign o_data_rd[p*REGISTERS_SIZE +: REGISTERS_SIZE] = rdat;
        assign o_rd_pending[p] = pend;
    end

    for (genvar j = 0; j < NUMBER_OF_REGISTERS; j++) begin : g_dbg
        assign o_Debugging[j*REGISTERS_SIZE +: REGISTERS_SIZE] = regs[j];
    end

    assign o_stall        = |o_rd_pending;
    assign o_pending_mask = sb;

endmodule
